// File: rtl/spring_solver.sv
// Soft-body spring force stage: snapshots nodes and springs, accumulates Hooke forces one spring
// per cycle, then integrates velocities one node per cycle. Define SPRING_DAMPING_EN for damping.
module spring_solver #(
  parameter int DT            = 1,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int NUM_NODES     = 4,
  parameter int NUM_SPRINGS   = 6,
  parameter int K_SHIFT       = 2,
  parameter int DAMP_SHIFT    = 3,
  parameter int GRAVITY       = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            begin_in,
  input  logic signed [POSITION_SIZE-1:0] pos_x_in    [NUM_NODES],
  input  logic signed [POSITION_SIZE-1:0] pos_y_in    [NUM_NODES],
  input  logic signed [VELOCITY_SIZE-1:0] vel_x_in    [NUM_NODES],
  input  logic signed [VELOCITY_SIZE-1:0] vel_y_in    [NUM_NODES],
  input  logic [$clog2(NUM_NODES):0]      spring_a_in [NUM_SPRINGS],
  input  logic [$clog2(NUM_NODES):0]      spring_b_in [NUM_SPRINGS],
  input  logic signed [POSITION_SIZE-1:0] rest_dx_in  [NUM_SPRINGS],
  input  logic signed [POSITION_SIZE-1:0] rest_dy_in  [NUM_SPRINGS],
  output logic signed [VELOCITY_SIZE-1:0] new_vel_x   [NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] new_vel_y   [NUM_NODES],
  output logic                            busy_out,
  output logic                            result_out
);

  localparam int IW = $clog2(NUM_NODES) + 1;
  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int SW = (NUM_SPRINGS > 1) ? $clog2(NUM_SPRINGS) : 1;
  localparam int AW = FORCE_SIZE + $clog2(NUM_SPRINGS) + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SPRINGS   = 2'd1;
  localparam logic [1:0] INTEGRATE = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  logic [1:0]    state_q;
  logic [SW-1:0] spr_idx_q;
  logic [NW-1:0] node_idx_q;

  logic signed [POSITION_SIZE-1:0] pos_x_q   [NUM_NODES];
  logic signed [POSITION_SIZE-1:0] pos_y_q   [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vel_x_q   [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vel_y_q   [NUM_NODES];
  logic [IW-1:0]                   spr_a_q   [NUM_SPRINGS];
  logic [IW-1:0]                   spr_b_q   [NUM_SPRINGS];
  logic signed [POSITION_SIZE-1:0] rest_dx_q [NUM_SPRINGS];
  logic signed [POSITION_SIZE-1:0] rest_dy_q [NUM_SPRINGS];
  logic signed [AW-1:0]            acc_x_q   [NUM_NODES];
  logic signed [AW-1:0]            acc_y_q   [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vout_x_q  [NUM_NODES];
  logic signed [VELOCITY_SIZE-1:0] vout_y_q  [NUM_NODES];

  function automatic logic signed [FORCE_SIZE-1:0] sat_force(input logic signed [31:0] v);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (FORCE_SIZE - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (FORCE_SIZE - 1));
    if (v > hi) return hi[FORCE_SIZE-1:0];
    if (v < lo) return lo[FORCE_SIZE-1:0];
    return v[FORCE_SIZE-1:0];
  endfunction

  function automatic logic signed [VELOCITY_SIZE-1:0] sat_vel(input logic signed [31:0] v);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (VELOCITY_SIZE - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (VELOCITY_SIZE - 1));
    if (v > hi) return hi[VELOCITY_SIZE-1:0];
    if (v < lo) return lo[VELOCITY_SIZE-1:0];
    return v[VELOCITY_SIZE-1:0];
  endfunction

  // Spring datapath for the current spring index.
  logic [IW-1:0]                sa, sb;
  logic [NW-1:0]                ia, ib;
  logic                         spring_ok;
  logic signed [31:0]           ex, ey;
  logic signed [FORCE_SIZE-1:0] fx, fy;
  logic signed [AW-1:0]         acc_xa, acc_xb, acc_ya, acc_yb;

  always_comb begin
    sa        = spr_a_q[spr_idx_q];
    sb        = spr_b_q[spr_idx_q];
    ia        = sa[NW-1:0];
    ib        = sb[NW-1:0];
    spring_ok = (sa != sb) && (int'(sa) < NUM_NODES) && (int'(sb) < NUM_NODES);
    ex        = 32'(pos_x_q[ib]) - 32'(pos_x_q[ia]) - 32'(rest_dx_q[spr_idx_q]);
    ey        = 32'(pos_y_q[ib]) - 32'(pos_y_q[ia]) - 32'(rest_dy_q[spr_idx_q]);
    fx        = sat_force(ex >>> K_SHIFT);
    fy        = sat_force(ey >>> K_SHIFT);
    acc_xa    = acc_x_q[ia] + AW'(fx);
    acc_xb    = acc_x_q[ib] - AW'(fx);
    acc_ya    = acc_y_q[ia] + AW'(fy);
    acc_yb    = acc_y_q[ib] - AW'(fy);
  end

  // Integration datapath for the current node index.
  logic signed [31:0]              damp_x, damp_y;
  logic signed [VELOCITY_SIZE-1:0] vx_new, vy_new;

`ifndef SPRING_DAMPING_EN
  logic unused_damp_shift;
  assign unused_damp_shift = (DAMP_SHIFT != 0);
`endif

  always_comb begin
`ifdef SPRING_DAMPING_EN
    damp_x = 32'(vel_x_q[node_idx_q]) >>> DAMP_SHIFT;
    damp_y = 32'(vel_y_q[node_idx_q]) >>> DAMP_SHIFT;
`else
    damp_x = '0;
    damp_y = '0;
`endif
    vx_new = sat_vel(32'(vel_x_q[node_idx_q]) + (32'(acc_x_q[node_idx_q]) - damp_x) * DT);
    vy_new = sat_vel(32'(vel_y_q[node_idx_q]) + (32'(acc_y_q[node_idx_q]) - damp_y) * DT
                     - GRAVITY * DT);
  end

  // Snapshot is only taken on an accepted start, so inputs may move freely afterwards.
  always_ff @(posedge clk_in) begin
    if (state_q == IDLE && begin_in) begin
      pos_x_q   <= pos_x_in;
      pos_y_q   <= pos_y_in;
      vel_x_q   <= vel_x_in;
      vel_y_q   <= vel_y_in;
      spr_a_q   <= spring_a_in;
      spr_b_q   <= spring_b_in;
      rest_dx_q <= rest_dx_in;
      rest_dy_q <= rest_dy_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      spr_idx_q  <= '0;
      node_idx_q <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        acc_x_q[i]   <= '0;
        acc_y_q[i]   <= '0;
        vout_x_q[i]  <= '0;
        vout_y_q[i]  <= '0;
        new_vel_x[i] <= '0;
        new_vel_y[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (begin_in) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              acc_x_q[i] <= '0;
              acc_y_q[i] <= '0;
            end
            spr_idx_q <= '0;
            state_q   <= SPRINGS;
          end
        end
        SPRINGS: begin
          if (spring_ok) begin
            acc_x_q[ia] <= acc_xa;
            acc_x_q[ib] <= acc_xb;
            acc_y_q[ia] <= acc_ya;
            acc_y_q[ib] <= acc_yb;
          end
          if (spr_idx_q == SW'(NUM_SPRINGS - 1)) begin
            spr_idx_q  <= '0;
            node_idx_q <= '0;
            state_q    <= INTEGRATE;
          end else begin
            spr_idx_q <= spr_idx_q + SW'(1);
          end
        end
        INTEGRATE: begin
          vout_x_q[node_idx_q] <= vx_new;
          vout_y_q[node_idx_q] <= vy_new;
          if (node_idx_q == NW'(NUM_NODES - 1)) begin
            // Last node bypasses its register so outputs are valid throughout DONE.
            for (int i = 0; i < NUM_NODES; i++) begin
              new_vel_x[i] <= (NW'(i) == node_idx_q) ? vx_new : vout_x_q[i];
              new_vel_y[i] <= (NW'(i) == node_idx_q) ? vy_new : vout_y_q[i];
            end
            node_idx_q <= '0;
            state_q    <= DONE;
          end else begin
            node_idx_q <= node_idx_q + NW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_out   = (state_q != IDLE);
  assign result_out = (state_q == DONE);

endmodule

// File: tb/tb_spring_solver.sv
// Scoreboard bench for spring_solver: runs push expected velocities, a monitor checks each pulse.
module tb_spring_solver;

  logic clk = 1'b0;
  logic rst;
  logic begin_i;
  logic signed [7:0] pos_x [4];
  logic signed [7:0] pos_y [4];
  logic signed [7:0] vel_x [4];
  logic signed [7:0] vel_y [4];
  logic [2:0]        sp_a  [6];
  logic [2:0]        sp_b  [6];
  logic signed [7:0] rdx   [6];
  logic signed [7:0] rdy   [6];
  logic signed [7:0] nvx   [4];
  logic signed [7:0] nvy   [4];
  logic              busy;
  logic              result;

  spring_solver dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .begin_in    (begin_i),
    .pos_x_in    (pos_x),
    .pos_y_in    (pos_y),
    .vel_x_in    (vel_x),
    .vel_y_in    (vel_y),
    .spring_a_in (sp_a),
    .spring_b_in (sp_b),
    .rest_dx_in  (rdx),
    .rest_dy_in  (rdy),
    .new_vel_x   (nvx),
    .new_vel_y   (nvy),
    .busy_out    (busy),
    .result_out  (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0][7:0] vx;
    logic [3:0][7:0] vy;
    logic [31:0]     due;
  } exp_t;

  exp_t sb_q[$];
  exp_t nxt;
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (result) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result_pulse", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result_latency", cyc, int'(mon_e.due));
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("new_vel_x%0d", i), int'(nvx[i]), int'($signed(mon_e.vx[i])));
          chk($sformatf("new_vel_y%0d", i), int'(nvy[i]), int'($signed(mon_e.vy[i])));
        end
      end
    end
  end

  task automatic clear_vec();
    for (int i = 0; i < 4; i++) begin
      pos_x[i] = '0;
      pos_y[i] = '0;
      vel_x[i] = '0;
      vel_y[i] = '0;
    end
    for (int i = 0; i < 6; i++) begin
      sp_a[i] = '0;
      sp_b[i] = '0;
      rdx[i]  = '0;
      rdy[i]  = '0;
    end
  endtask

  task automatic set_exp(input int x0, input int x1, input int x2, input int x3,
                         input int y0, input int y1, input int y2, input int y3);
    nxt.vx[0] = 8'(x0);
    nxt.vx[1] = 8'(x1);
    nxt.vx[2] = 8'(x2);
    nxt.vx[3] = 8'(x3);
    nxt.vy[0] = 8'(y0);
    nxt.vy[1] = 8'(y1);
    nxt.vy[2] = 8'(y2);
    nxt.vy[3] = 8'(y3);
  endtask

  // One run at minimum period; inputs are scrambled after sampling to prove the snapshot.
  task automatic run(input string name);
    @(negedge clk);
    begin_i = 1'b1;
    @(posedge clk);
    #1;
    nxt.due = 32'(cyc + 10);
    sb_q.push_back(nxt);
    chk({name, "_busy_after_begin"}, int'(busy), 1);
    begin_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pos_x[i] = 8'($urandom);
      vel_x[i] = 8'($urandom);
      vel_y[i] = 8'($urandom);
    end
    repeat (12) @(negedge clk);
    chk({name, "_pending"}, sb_q.size(), 0);
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_result"}, int'(result), 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_vx%0d", name, i), int'(nvx[i]), 0);
      chk($sformatf("%s_vy%0d", name, i), int'(nvy[i]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    rst     = 1'b1;
    begin_i = 1'b0;
    clear_vec();
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single spring: ex=12-8=4, fx=1.
    clear_vec();
    sp_b[0] = 3'd1; rdx[0] = 8'sd8; pos_x[1] = 8'sd12;
    set_exp(1, -1, 0, 0, -1, -1, -1, -1);
    run("single");

    // Negative error: ex=3-8=-5, fx=-5>>>2=-2.
    clear_vec();
    sp_b[0] = 3'd1; rdx[0] = 8'sd8; pos_x[1] = 8'sd3;
    set_exp(-2, 2, 0, 0, -1, -1, -1, -1);
    run("negshift");

    // Several springs sharing node 0/1 plus a y-axis spring between 2 and 3.
    clear_vec();
    sp_b[0] = 3'd1; rdx[0] = 8'sd8; pos_x[1] = 8'sd12;
    sp_a[1] = 3'd2; sp_b[1] = 3'd3; pos_y[3] = -8'sd20;
    sp_a[2] = 3'd1; sp_b[2] = 3'd0; rdx[2] = -8'sd4;
    set_exp(3, -3, 0, 0, -1, -1, -6, 4);
    run("multi");

    // Saturation: fx=+4 into a node at vel 127; node 2 y at -128 minus gravity.
    clear_vec();
    sp_b[0] = 3'd1; rdx[0] = 8'sd8; pos_x[1] = 8'sd24;
    vel_x[0] = 8'sd127; vel_y[2] = -8'sd128;
`ifdef SPRING_DAMPING_EN
    set_exp(116, -4, 0, 0, -1, -1, -113, -1);
`else
    set_exp(127, -4, 0, 0, -1, -1, -128, -1);
`endif
    run("saturate");

    // Damping only: vel 16, no springs active.
    clear_vec();
    vel_x[0] = 8'sd16;
`ifdef SPRING_DAMPING_EN
    set_exp(14, 0, 0, 0, -1, -1, -1, -1);
`else
    set_exp(16, 0, 0, 0, -1, -1, -1, -1);
`endif
    run("damping");

    // Out-of-range endpoint must be skipped, not aliased onto node 3.
    clear_vec();
    sp_a[0] = 3'd0; sp_b[0] = 3'd7; pos_x[3] = 8'sd40;
    set_exp(0, 0, 0, 0, -1, -1, -1, -1);
    run("invalid_idx");

    // begin held high: exactly two runs across 24 cycles.
    clear_vec();
    sp_b[0] = 3'd1; rdx[0] = 8'sd8; pos_x[1] = 8'sd12;
    set_exp(1, -1, 0, 0, -1, -1, -1, -1);
    @(negedge clk);
    begin_i = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    nxt.due = 32'(c0 + 10);
    sb_q.push_back(nxt);
    nxt.due = 32'(c0 + 22);
    sb_q.push_back(nxt);
    repeat (20) @(negedge clk);
    begin_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_pending", sb_q.size(), 0);
    chk("held_idle", int'(busy), 0);

    // Reset on cycle 5 of a run: abort, clear outputs, no pulse.
    @(negedge clk);
    begin_i = 1'b1;
    @(posedge clk);
    #1;
    begin_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cleared("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk_cleared("after_reset");
    chk("final_queue_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spring_solver.md
# spring_solver

Soft-body force stage directly upstream of the per-point collision/integration stage. On `begin_in` it latches a snapshot of every node's position and velocity plus the spring table, then accumulates per-axis Hooke forces one spring per cycle. It integrates the forces, gravity and optional damping into new velocities one node per cycle. The point updater then consumes those velocities one node at a time.

## Interface
Parameters:
- `DT`, 1: integer timestep multiplier.
- `POSITION_SIZE`, 8: signed position width.
- `VELOCITY_SIZE`, 8: signed velocity width.
- `FORCE_SIZE`, 8: signed per-spring force width.
- `NUM_NODES`, 4: nodes in the body.
- `NUM_SPRINGS`, 6: spring table entries.
- `K_SHIFT`, 2: stiffness, applied as an arithmetic right shift.
- `DAMP_SHIFT`, 3: damping, applied as an arithmetic right shift.
- `GRAVITY`, 1: velocity subtracted from y per DT.

Ports:
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `begin_in`  in  1  start request; sampled only in IDLE.
- `pos_x_in`, `pos_y_in`  in  `[POSITION_SIZE-1:0]` x `[NUM_NODES]`  signed node positions.
- `vel_x_in`, `vel_y_in`  in  `[VELOCITY_SIZE-1:0]` x `[NUM_NODES]`  signed node velocities.
- `spring_a_in`, `spring_b_in`  in  `[$clog2(NUM_NODES):0]` x `[NUM_SPRINGS]`  endpoint node indices.
- `rest_dx_in`, `rest_dy_in`  in  `[POSITION_SIZE-1:0]` x `[NUM_SPRINGS]`  signed rest offset, b minus a.
- `new_vel_x`, `new_vel_y`  out  `[VELOCITY_SIZE-1:0]` x `[NUM_NODES]`  updated velocities.
- `busy_out`  out  1  high whenever the FSM is not in IDLE.
- `result_out`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SPRINGS, INTEGRATE, DONE.
- **IDLE**, on `begin_in`=1:
  - Latch all inputs.
  - Clear the per-node accumulators `acc_x` and `acc_y`.
  - Set spring index to 0 and go to SPRINGS.
- **SPRINGS**, one spring per cycle, index s:
  - dx = pos_x[b] - pos_x[a], computed at `POSITION_SIZE+1` bits.
  - ex = dx - rest_dx.
  - fx = (ex >>> K_SHIFT), saturated to `FORCE_SIZE` signed.
  - acc_x[a] += fx and acc_x[b] -= fx. The y axis is handled identically.
  - A spring is skipped (no accumulator change) if a==b or if either index ≥ NUM_NODES.
  - After s = NUM_SPRINGS-1, set node index to 0 and go to INTEGRATE.
- Accumulator width is `FORCE_SIZE+$clog2(NUM_SPRINGS)+1`, so accumulators never overflow.
- **INTEGRATE**, one node per cycle, index n:
  - v' = vel_x[n] + (acc_x[n] - damp_x) * DT.
  - y axis additionally subtracts GRAVITY * DT.
  - damp = vel >>> DAMP_SHIFT when damping is compiled in, otherwise 0.
  - Result is saturated to `VELOCITY_SIZE` signed and stored in an internal register.
  - After n = NUM_NODES-1, go to DONE.
- **DONE**:
  - Copy all internal velocity registers to `new_vel_x`/`new_vel_y` simultaneously.
  - Pulse `result_out` and return to IDLE.
- `new_vel_*` hold their value between runs and change only on entry to DONE.
- `begin_in` is ignored while `busy_out`=1. Latched inputs may change freely after the sampling edge.

## Timing
- Reset values:
  - State IDLE.
  - `result_out`=0, `busy_out`=0.
  - All `new_vel_*`=0.
  - Accumulators and indices = 0.
- Reset mid-run aborts immediately. No `result_out` pulse is produced, and `new_vel_*` are cleared to 0.
- Let edge E0 sample `begin_in`=1.
  - `busy_out` is high after E0.
  - SPRINGS occupies the NUM_SPRINGS cycles after E0.
  - INTEGRATE occupies the following NUM_NODES cycles.
  - DONE occupies one cycle, during which `result_out`=1 and `new_vel_*` are already valid.
- With defaults, `result_out` is high during the 11th cycle after E0.
- Back-to-back runs: `begin_in` is honoured on the edge that leaves DONE→IDLE +1. The minimum period is NUM_SPRINGS+NUM_NODES+2 cycles.
- Saturation points:
  - fx is clamped at ±(2^(FORCE_SIZE-1)), using -2^(FORCE_SIZE-1) and 2^(FORCE_SIZE-1)-1.
  - v' is clamped to [-2^(VELOCITY_SIZE-1), 2^(VELOCITY_SIZE-1)-1].

## Configuration
- `SPRING_DAMPING_EN` defined: damping term vel>>>DAMP_SHIFT is subtracted per axis in INTEGRATE.
- `SPRING_DAMPING_EN` undefined: damping term is 0 and `DAMP_SHIFT` is unused.
- Latency is identical in both builds.

## Test plan
All scenarios use the default parameters.
- **Single spring:**
  - Stimulus: spring0 a=0, b=1, rest_dx=8, rest_dy=0. pos_x0=0, pos_x1=12, all y=0, all vel=0. Springs 1–5 have a==b.
  - Required response: new_vel_x0=1, new_vel_x1=-1, new_vel_x2=new_vel_x3=0, all new_vel_y=-1. `result_out` pulses once, 11 cycles after begin.
- **Negative shift:**
  - Stimulus: pos_x1 - pos_x0 - rest_dx = -5.
  - Required response: fx=-2 (arithmetic shift), so new_vel_x0=-2 and new_vel_x1=+2.
- **Saturation:**
  - Stimulus: vel_x0=127 with fx=+4 into node 0; separately vel_y2=-128 with no spring.
  - Required response: new_vel_x0=127 and new_vel_y2=-128.
- **Damping:**
  - Stimulus: vel_x0=16, no springs active.
  - Required response: new_vel_x0=14 with `SPRING_DAMPING_EN`, 16 without it.
- **Busy and reset:**
  - Stimulus: `begin_in` held high throughout a run, then `rst_in` asserted on cycle 5 of a second run.
  - Required response: exactly one `result_out` pulse per 12-cycle period. After the reset, `busy_out`=0 and all `new_vel_*`=0, with no pulse.
- **Invalid index:**
  - Stimulus: spring a=0, b=7.
  - Required response: spring skipped; node 0 velocity is affected only by gravity.
